// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: opcodes, ALUOp and pc_src encodings, control FSM states.
// Used by the main control FSM and by the ALU control decoder.
package risc16_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned PCSRC_W  = 2;

  localparam logic [OPC_W-1:0] OPC_LD    = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_ST    = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_ILL_A = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_BNE   = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_ILL_E = 4'b1110;
  localparam logic [OPC_W-1:0] OPC_ILL_F = 4'b1111;

  localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b10;

  localparam logic [PCSRC_W-1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_SRC_BR  = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_SRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bus between the main control FSM (master) and the datapath/memory side (slave).
interface main_control_fsm_if;
  import risc16_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic               alu_zero;
  logic               mem_ready;
  logic [ALUOP_W-1:0] ALUOp;
  logic               imem_rd;
  logic               dmem_rd;
  logic               dmem_wr;
  logic               ir_we;
  logic               pc_we;
  logic               reg_we;
  logic               alu_out_we;
  logic [PCSRC_W-1:0] pc_src;
  logic               reg_dst;
  logic               alu_src;
  logic               mem_to_reg;
  logic               retire;
  logic               trap;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output ALUOp, imem_rd, dmem_rd, dmem_wr, ir_we, pc_we, reg_we, alu_out_we,
           pc_src, reg_dst, alu_src, mem_to_reg, retire, trap
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  ALUOp, imem_rd, dmem_rd, dmem_wr, ir_we, pc_we, reg_we, alu_out_we,
           pc_src, reg_dst, alu_src, mem_to_reg, retire, trap
  );

endinterface

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier; every opcode not named explicitly is R-type (0010-1001).
module opcode_class_decode
  import risc16_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             is_ld,
  output logic             is_st,
  output logic             is_r,
  output logic             is_br,
  output logic             is_bne,
  output logic             is_jmp,
  output logic             is_illegal
);

  always_comb begin
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_r       = 1'b0;
    is_br      = 1'b0;
    is_bne     = 1'b0;
    is_jmp     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_LD:  is_ld = 1'b1;
      OPC_ST:  is_st = 1'b1;
      OPC_BEQ: is_br = 1'b1;
      OPC_BNE: begin
        is_br  = 1'b1;
        is_bne = 1'b1;
      end
      OPC_JMP: is_jmp = 1'b1;
      OPC_ILL_A, OPC_ILL_E, OPC_ILL_F: is_illegal = 1'b1;
      default: is_r = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle RISC16 main control: FETCH/DECODE/EXEC/MEM/WB sequencing with memory stalls.
// Optional RISC16_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP instead of retiring as NOP.
module main_control_fsm
  import risc16_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  main_control_fsm_if.master  bus
);

  state_t state;
  state_t state_nxt;

  logic is_ld, is_st, is_r, is_br, is_bne, is_jmp, is_illegal;

  opcode_class_decode u_decode (
    .opcode     (bus.opcode),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_r       (is_r),
    .is_br      (is_br),
    .is_bne     (is_bne),
    .is_jmp     (is_jmp),
    .is_illegal (is_illegal)
  );

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; mem_ready only matters in FETCH and MEM.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (bus.mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (is_ld || is_st)   state_nxt = ST_MEM;
        else if (is_r)        state_nxt = ST_WB;
`ifdef RISC16_ILLEGAL_TRAP_EN
        else if (is_illegal)  state_nxt = ST_TRAP;
`endif
        else                  state_nxt = ST_FETCH;
      end
      ST_MEM:    if (bus.mem_ready) state_nxt = is_ld ? ST_WB : ST_FETCH;
      ST_WB:     state_nxt = ST_FETCH;
`ifdef RISC16_ILLEGAL_TRAP_EN
      ST_TRAP:   state_nxt = ST_TRAP;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state plus opcode/alu_zero/mem_ready.
  always_comb begin
    bus.ALUOp      = ALUOP_R;
    bus.imem_rd    = 1'b0;
    bus.dmem_rd    = 1'b0;
    bus.dmem_wr    = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.alu_out_we = 1'b0;
    bus.pc_src     = PC_SRC_SEQ;
    bus.reg_dst    = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.retire     = 1'b0;
    bus.trap       = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.imem_rd = 1'b1;
        bus.ir_we   = bus.mem_ready;
        bus.pc_we   = bus.mem_ready;
      end
      ST_EXEC: begin
        if (is_ld || is_st) begin
          bus.ALUOp      = ALUOP_MEM;
          bus.alu_src    = 1'b1;
          bus.alu_out_we = 1'b1;
        end else if (is_r) begin
          bus.ALUOp      = ALUOP_R;
          bus.alu_out_we = 1'b1;
        end else if (is_br) begin
          bus.ALUOp  = ALUOP_BR;
          bus.pc_src = PC_SRC_BR;
          bus.pc_we  = bus.alu_zero ^ is_bne;
          bus.retire = 1'b1;
        end else if (is_jmp) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_SRC_JMP;
          bus.retire = 1'b1;
        end else begin
`ifndef RISC16_ILLEGAL_TRAP_EN
          bus.retire = is_illegal;
`endif
        end
      end
      ST_MEM: begin
        bus.ALUOp   = ALUOP_MEM;
        bus.dmem_rd = is_ld;
        bus.dmem_wr = is_st;
        bus.retire  = is_st && bus.mem_ready;
      end
      ST_WB: begin
        bus.reg_we = 1'b1;
        bus.retire = 1'b1;
        if (is_ld) begin
          bus.ALUOp      = ALUOP_MEM;
          bus.mem_to_reg = 1'b1;
        end else begin
          bus.reg_dst = 1'b1;
        end
      end
`ifdef RISC16_ILLEGAL_TRAP_EN
      ST_TRAP:   bus.trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: per-cycle expected control vectors queued per instruction.
module tb_main_control_fsm;

  logic clk = 1'b0;
  logic reset;

  main_control_fsm_if bus_if ();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] aluop;
    logic       imem_rd;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       alu_out_we;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       retire;
    logic       trap;
  } out_t;

  typedef struct {
    logic       mr;
    logic [3:0] opc;
    logic       az;
    out_t       exp;
    int         id;
    int         cyc;
  } step_t;

  step_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int instr_id = 0;
  int cyc_id   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.aluop      = bus_if.ALUOp;
    o.imem_rd    = bus_if.imem_rd;
    o.dmem_rd    = bus_if.dmem_rd;
    o.dmem_wr    = bus_if.dmem_wr;
    o.ir_we      = bus_if.ir_we;
    o.pc_we      = bus_if.pc_we;
    o.reg_we     = bus_if.reg_we;
    o.alu_out_we = bus_if.alu_out_we;
    o.pc_src     = bus_if.pc_src;
    o.reg_dst    = bus_if.reg_dst;
    o.alu_src    = bus_if.alu_src;
    o.mem_to_reg = bus_if.mem_to_reg;
    o.retire     = bus_if.retire;
    o.trap       = bus_if.trap;
    return o;
  endfunction

  task automatic push(input logic mr, input logic [3:0] opc, input logic az, input out_t e);
    step_t s;
    s.mr = mr; s.opc = opc; s.az = az; s.exp = e;
    s.id = instr_id; s.cyc = cyc_id;
    cyc_id++;
    sb.push_back(s);
  endtask

  // Queue the expected per-cycle vectors of one instruction; stop_mem ends it inside MEM.
  task automatic push_instr(input logic [3:0] opc, input logic az, input int fw,
                            input int mw, input bit stop_mem);
    out_t e;
    bit ld, st, br, jmp, ill, r;
    ld  = (opc == 4'b0000);
    st  = (opc == 4'b0001);
    br  = (opc == 4'b1011) || (opc == 4'b1100);
    jmp = (opc == 4'b1101);
    ill = (opc == 4'b1010) || (opc == 4'b1110) || (opc == 4'b1111);
    r   = !(ld || st || br || jmp || ill);
    instr_id++;
    cyc_id = 0;
    for (int k = 0; k < fw; k++) begin
      e = '0; e.imem_rd = 1'b1;
      push(1'b0, opc, az, e);
    end
    e = '0; e.imem_rd = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(1'b1, opc, az, e);
    e = '0;
    push(1'b0, opc, az, e);
    e = '0;
    if (ld || st) begin
      e.aluop = 2'b10; e.alu_src = 1'b1; e.alu_out_we = 1'b1;
    end else if (r) begin
      e.alu_out_we = 1'b1;
    end else if (br) begin
      e.aluop = 2'b01; e.pc_src = 2'b01; e.retire = 1'b1;
      e.pc_we = (opc == 4'b1011) ? az : !az;
    end else if (jmp) begin
      e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
    end else begin
`ifndef RISC16_ILLEGAL_TRAP_EN
      e.retire = 1'b1;
`endif
    end
    push(1'b0, opc, az, e);
    if (ld || st) begin
      for (int k = 0; k < mw; k++) begin
        e = '0; e.aluop = 2'b10; e.dmem_rd = ld; e.dmem_wr = st;
        push(1'b0, opc, az, e);
      end
      if (stop_mem) return;
      e = '0; e.aluop = 2'b10; e.dmem_rd = ld; e.dmem_wr = st; e.retire = st;
      push(1'b1, opc, az, e);
    end
    if (ld || r) begin
      e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
      if (ld) begin e.aluop = 2'b10; e.mem_to_reg = 1'b1; end
      else    e.reg_dst = 1'b1;
      push(1'b0, opc, az, e);
    end
  endtask

  // Drive each queued step mid-cycle and compare against its expected vector.
  task automatic run_sb();
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      bus_if.mem_ready = s.mr;
      bus_if.opcode    = s.opc;
      bus_if.alu_zero  = s.az;
      #1;
      chk($sformatf("i%0d_c%0d_op%0h", s.id, s.cyc, s.opc), 32'(sample()), 32'(s.exp));
    end
  endtask

  task automatic release_and_check_idle(input string tag);
    @(negedge clk);
    reset = 1'b0;
    bus_if.mem_ready = 1'b1;
    #1;
    chk(tag, 32'(sample()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.mem_ready = 1'b1;
    bus_if.opcode    = 4'b0000;
    bus_if.alu_zero  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", 32'(sample()), 32'd0);
    release_and_check_idle("idle_after_reset");

    push_instr(4'b0010, 1'b0, 0, 0, 1'b0);   // ADD
    push_instr(4'b0000, 1'b0, 0, 2, 1'b0);   // LD, 2 wait states
    push_instr(4'b1011, 1'b1, 0, 0, 1'b0);   // BEQ taken
    push_instr(4'b1100, 1'b1, 0, 0, 1'b0);   // BNE not taken
    push_instr(4'b1100, 1'b0, 0, 0, 1'b0);   // BNE taken
    push_instr(4'b1011, 1'b0, 1, 0, 1'b0);   // BEQ not taken, fetch wait
    push_instr(4'b1101, 1'b0, 0, 0, 1'b0);   // JMP
    push_instr(4'b0001, 1'b0, 2, 1, 1'b0);   // ST with waits
    push_instr(4'b1001, 1'b1, 0, 0, 1'b0);   // SLT
    push_instr(4'b0000, 1'b1, 0, 0, 1'b0);   // LD zero wait
    run_sb();

    push_instr(4'b0001, 1'b0, 0, 1, 1'b1);   // ST stalled in MEM
    run_sb();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_mem_dmem_wr", 32'(bus_if.dmem_wr), 32'd0);
    chk("rst_mid_mem_all", 32'(sample()), 32'd0);
    release_and_check_idle("idle_after_mid_reset");
    push_instr(4'b0011, 1'b0, 0, 0, 1'b0);
    run_sb();

    push_instr(4'b1111, 1'b0, 0, 0, 1'b0);
`ifdef RISC16_ILLEGAL_TRAP_EN
    begin
      out_t e;
      e = '0; e.trap = 1'b1;
      for (int k = 0; k < 20; k++) push(1'b1, 4'b1111, 1'b0, e);
    end
    run_sb();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("trap_cleared_by_reset", 32'(bus_if.trap), 32'd0);
    release_and_check_idle("idle_after_trap");
`endif
    push_instr(4'b1101, 1'b0, 0, 0, 1'b0);
    run_sb();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
